reg_dump: RTL and testbench

Register-file readout engine for the pipelined RV32I core. It is the export counterpart of the register preload path: on a `start` pulse it walks the architectural registers through a register-file read port and streams each 32-bit value out over a valid/ready handshake, so that the host GUI can retrieve final register state. While a dump is in progress it asserts a stall request, which the top level uses to freeze the pipeline. The top level also muxes `rd_addr` onto the register file's A read port.

---
 rtl/reg_dump.sv | 131 +++++++++++++
 tb/tb_reg_dump.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump.sv
// reg_dump: register-file readout engine.
// On a start pulse, walks register indices FIRST_REG..LAST_REG through a
// register-file read port and streams each value over a valid/ready handshake.
// Ports:
//   clk, rst (async, active-low)
//   start                      - dump request, sampled only while idle
//   rd_addr / rd_data          - register-file read port (data is combinational)
//   out_valid/out_ready        - beat handshake
//   out_data/out_idx/out_last  - beat payload
//   busy, stall_req            - dump in progress (pipeline freeze)
//   done                       - one-cycle pulse after the final beat
module reg_dump #(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [4:0]  out_idx,
    output logic        out_last,
    output logic        busy,
    output logic        stall_req,
    output logic        done
);
    localparam int unsigned IDX_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(FIRST_REG);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(LAST_REG);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SEND,
        S_DONE
    } state_t;

    state_t              state, state_d;
    logic [IDX_W-1:0]    idx, idx_d;
    logic [IDX_W-1:0]    rd_addr_d;
    logic                out_valid_d;
    logic [DATA_W-1:0]   out_data_d;
    logic [IDX_W-1:0]    out_idx_d;
    logic                out_last_d;
    logic                busy_d;
    logic                done_d;

    // Next-state and next-output logic
    always_comb begin
        state_d     = state;
        idx_d       = idx;
        rd_addr_d   = rd_addr;
        out_valid_d = out_valid;
        out_data_d  = out_data;
        out_idx_d   = out_idx;
        out_last_d  = out_last;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_LOAD;
                    idx_d     = FIRST_IDX;
                    rd_addr_d = FIRST_IDX;
                end
            end
            S_LOAD: begin
                // Single capture point; later register writes cannot alter this beat
                out_data_d  = rd_data;
                out_idx_d   = idx;
                out_last_d  = (idx == LAST_IDX);
                out_valid_d = 1'b1;
                state_d     = S_SEND;
            end
            S_SEND: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    if (idx == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        // rd_addr moves with idx so it is stable for the whole LOAD cycle
                        idx_d     = idx + IDX_W'(1);
                        rd_addr_d = idx + IDX_W'(1);
                        state_d   = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Status flags are registered from the next state so they align with it
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            idx       <= FIRST_IDX;
            rd_addr   <= FIRST_IDX;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_idx   <= '0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            stall_req <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            rd_addr   <= rd_addr_d;
            out_valid <= out_valid_d;
            out_data  <= out_data_d;
            out_idx   <= out_idx_d;
            out_last  <= out_last_d;
            busy      <= busy_d;
            stall_req <= busy_d;
            done      <= done_d;
        end
    end

endmodule

// File: tb/tb_reg_dump.sv
// tb_reg_dump: directed bench for reg_dump (full range and a 5..7 sub-range instance).
module tb_reg_dump;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start;
    logic        out_ready;
    logic        sel;

    logic [31:0] regs [32];

    // Full-range instance
    logic [4:0]  rd_addr0;
    logic [31:0] rd_data0;
    logic        v0, l0, b0, s0, d0;
    logic [31:0] dat0;
    logic [4:0]  ix0;
    logic        start0;

    // Sub-range instance
    logic [4:0]  rd_addr1;
    logic [31:0] rd_data1;
    logic        v1, l1, b1, s1, d1;
    logic [31:0] dat1;
    logic [4:0]  ix1;
    logic        start1;

    assign start0   = start & ~sel;
    assign start1   = start & sel;
    assign rd_data0 = (rd_addr0 == 5'd0) ? 32'h0 : regs[rd_addr0];
    assign rd_data1 = (rd_addr1 == 5'd0) ? 32'h0 : regs[rd_addr1];

    reg_dump dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .rd_addr(rd_addr0), .rd_data(rd_data0),
        .out_valid(v0), .out_ready(out_ready),
        .out_data(dat0), .out_idx(ix0), .out_last(l0),
        .busy(b0), .stall_req(s0), .done(d0)
    );

    reg_dump #(.FIRST_REG(5), .LAST_REG(7)) dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .rd_addr(rd_addr1), .rd_data(rd_data1),
        .out_valid(v1), .out_ready(out_ready),
        .out_data(dat1), .out_idx(ix1), .out_last(l1),
        .busy(b1), .stall_req(s1), .done(d1)
    );

    // Observation mux for whichever instance is under test
    logic        m_valid, m_last, m_busy, m_stall, m_done;
    logic [31:0] m_data;
    logic [4:0]  m_idx, m_addr;
    assign m_valid = sel ? v1 : v0;
    assign m_last  = sel ? l1 : l0;
    assign m_busy  = sel ? b1 : b0;
    assign m_stall = sel ? s1 : s0;
    assign m_done  = sel ? d1 : d0;
    assign m_data  = sel ? dat1 : dat0;
    assign m_idx   = sel ? ix1 : ix0;
    assign m_addr  = sel ? rd_addr1 : rd_addr0;

    int compared   = 0;
    int mismatched = 0;

    int          q_idx[$];
    logic [31:0] q_data[$];
    bit          q_last[$];
    logic [31:0] exp_mem [32];
    int          done_cyc, done_cnt, busy_bad, stall_bad, hold_bad;
    bit          found;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Expected dump contents: x0 always reads as zero
    task automatic snapshot();
        for (int i = 0; i < 32; i++) exp_mem[i] = (i == 0) ? 32'h0 : regs[i];
    endtask

    // Start a dump at cycle 0 and observe cycles 1..max_c, recording beats and flags
    task automatic run_dump(input int max_c, input int stall_idx, input int stall_len,
                            input int xs_a, input int xs_b, input bit late_wr,
                            input int exp_done);
        int          stall_left;
        bit          prev_stalled;
        bit          written;
        logic [31:0] prev_data;
        logic [4:0]  prev_idx;
        q_idx.delete(); q_data.delete(); q_last.delete();
        done_cyc = -1; done_cnt = 0; busy_bad = 0; stall_bad = 0; hold_bad = 0;
        stall_left = stall_len; prev_stalled = 0; written = 0;
        prev_data = '0; prev_idx = '0;
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b1;
        for (int c = 1; c <= max_c; c++) begin
            @(negedge clk);
            start = (c == xs_a) || (c == xs_b);
            if (m_busy !== (c <= exp_done)) busy_bad++;
            if (m_stall !== m_busy) stall_bad++;
            if (m_done === 1'b1) begin
                done_cnt++;
                done_cyc = c;
            end
            if (late_wr && !written && m_valid === 1'b1 && m_idx == 5'd4) begin
                regs[4] = 32'hDEADBEEF;
                written = 1;
            end
            if (stall_idx >= 0 && m_valid === 1'b1 && int'(m_idx) == stall_idx && stall_left > 0) begin
                out_ready = 1'b0;
                stall_left--;
                if (prev_stalled && (m_data !== prev_data || m_idx !== prev_idx)) hold_bad++;
                prev_stalled = 1;
                prev_data = m_data;
                prev_idx = m_idx;
            end else begin
                out_ready = 1'b1;
                prev_stalled = 0;
            end
            if (m_valid === 1'b1 && out_ready) begin
                q_idx.push_back(int'(m_idx));
                q_data.push_back(m_data);
                q_last.push_back(m_last);
            end
        end
        start = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic check_beats(input string tag, input int first, input int last);
        int bad_idx;
        int bad_data;
        int bad_last;
        int e;
        bad_idx = 0; bad_data = 0; bad_last = 0;
        chk({tag, "_count"}, 32'(q_idx.size()), 32'(last - first + 1));
        for (int k = 0; k < q_idx.size(); k++) begin
            e = first + k;
            if (q_idx[k] != e) bad_idx++;
            if (e > 31 || q_data[k] !== exp_mem[e]) bad_data++;
            if (q_last[k] != (e == last)) bad_last++;
        end
        chk({tag, "_idx_errs"}, 32'(bad_idx), 32'd0);
        chk({tag, "_data_errs"}, 32'(bad_data), 32'd0);
        chk({tag, "_last_errs"}, 32'(bad_last), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        start = 1'b0;
        out_ready = 1'b1;
        sel = 1'b0;
        for (int i = 0; i < 32; i++) regs[i] = 32'hA5000000 + 32'(i);

        // Reset values while reset is held
        #12;
        chk("rst_rd_addr", 32'(rd_addr0), 32'd0);
        chk("rst_rd_addr_sub", 32'(rd_addr1), 32'd5);
        chk("rst_valid", 32'(v0), 32'd0);
        chk("rst_data", dat0, 32'd0);
        chk("rst_idx", 32'(ix0), 32'd0);
        chk("rst_last", 32'(l0), 32'd0);
        chk("rst_busy", 32'(b0), 32'd0);
        chk("rst_stall", 32'(s0), 32'd0);
        chk("rst_done", 32'(d0), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("idle_busy", 32'(b0), 32'd0);

        // Full dump, ready held high
        snapshot();
        run_dump(69, -1, 0, -1, -1, 1'b0, 65);
        check_beats("full", 0, 31);
        chk("full_beat0", (q_data.size() > 0) ? q_data[0] : 32'hX, 32'h0);
        chk("full_beat31", (q_data.size() > 31) ? q_data[31] : 32'hX, 32'hA500001F);
        chk("full_done_cyc", 32'(done_cyc), 32'd65);
        chk("full_done_cnt", 32'(done_cnt), 32'd1);
        chk("full_busy_window", 32'(busy_bad), 32'd0);
        chk("full_stall_eq_busy", 32'(stall_bad), 32'd0);

        // Backpressure on beat idx 3 for 5 cycles
        repeat (2) @(negedge clk);
        run_dump(74, 3, 5, -1, -1, 1'b0, 70);
        check_beats("bp", 0, 31);
        chk("bp_hold", 32'(hold_bad), 32'd0);
        chk("bp_done_cyc", 32'(done_cyc), 32'd70);
        chk("bp_busy_window", 32'(busy_bad), 32'd0);

        // Start pulses while busy (cycle 10 and the DONE cycle) are ignored
        repeat (2) @(negedge clk);
        run_dump(69, -1, 0, 10, 65, 1'b0, 65);
        check_beats("sb", 0, 31);
        chk("sb_done_cnt", 32'(done_cnt), 32'd1);
        chk("sb_done_cyc", 32'(done_cyc), 32'd65);
        chk("sb_busy_window", 32'(busy_bad), 32'd0);

        // Late write to x4 after its beat is captured
        repeat (2) @(negedge clk);
        snapshot();
        run_dump(69, -1, 0, -1, -1, 1'b1, 65);
        chk("late_old_x4", (q_data.size() > 4) ? q_data[4] : 32'hX, 32'hA5000004);
        check_beats("late", 0, 31);
        repeat (2) @(negedge clk);
        snapshot();
        run_dump(69, -1, 0, -1, -1, 1'b0, 65);
        chk("late_new_x4", (q_data.size() > 4) ? q_data[4] : 32'hX, 32'hDEADBEEF);
        check_beats("late2", 0, 31);

        // Reset asserted right after beat idx 10 transfers
        repeat (2) @(negedge clk);
        @(negedge clk);
        start = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int c = 0; c < 40 && !found; c++) begin
            if (v0 === 1'b1 && ix0 == 5'd10) found = 1;
            else @(negedge clk);
        end
        chk("mid_found_idx10", 32'(found), 32'd1);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("mid_rd_addr", 32'(rd_addr0), 32'd0);
        chk("mid_valid", 32'(v0), 32'd0);
        chk("mid_data", dat0, 32'd0);
        chk("mid_idx", 32'(ix0), 32'd0);
        chk("mid_busy", 32'(b0), 32'd0);
        chk("mid_stall", 32'(s0), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_dump(69, -1, 0, -1, -1, 1'b0, 65);
        check_beats("post_rst", 0, 31);
        chk("post_rst_done_cyc", 32'(done_cyc), 32'd65);

        // Sub-range instance: registers 5..7
        repeat (2) @(negedge clk);
        sel = 1'b1;
        @(negedge clk);
        run_dump(11, -1, 0, -1, -1, 1'b0, 7);
        check_beats("sub", 5, 7);
        chk("sub_done_cyc", 32'(done_cyc), 32'd7);
        chk("sub_done_cnt", 32'(done_cnt), 32'd1);
        chk("sub_busy_window", 32'(busy_bad), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
